// File: rtl/ip_tx_arbiter_if.sv
//==============================================================================
// Module   : ip_tx_arbiter_if
// Brief    : AXI-Stream beat bundle (data/keep/last/valid/ready/user) shared
//            by the IP TX upper-layer requesters and the arbiter output.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ip_tx_arbiter_if #(
    parameter int P_USER_W = 56
) ();
    logic [63:0]         data;
    logic [7:0]          keep;
    logic                last;
    logic                valid;
    logic                ready;
    logic [P_USER_W-1:0] user;

    // Source side drives the beat, sink side drives ready
    modport master (output data, keep, last, valid, user, input ready);
    modport slave  (input data, keep, last, valid, user, output ready);
endinterface

`default_nettype wire

// File: rtl/ip_tx_arbiter.sv
//==============================================================================
// Module   : ip_tx_arbiter
// Brief    : Two-port packet-granular arbiter in front of the IP TX upper
//            AXIS input. Port 0 = UDP, port 1 = ICMP. A grant is held from
//            the first to the last beat of a packet; a single register
//            slice drives the output. Per-port completed-packet counters.
// Config   : ARB_STRICT_PRIO_EN - when defined, port 1 wins every idle
//            contention; otherwise the two ports alternate round-robin.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ip_tx_arbiter #(
    parameter int P_USER_W = 56,
    parameter int P_CNT_W  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,          // asynchronous, active-low
    ip_tx_arbiter_if.slave       s_axis_p0,
    ip_tx_arbiter_if.slave       s_axis_p1,
    ip_tx_arbiter_if.master      m_axis_upper,
    output logic [P_CNT_W-1:0]   o_p0_pkt_cnt,
    output logic [P_CNT_W-1:0]   o_p1_pkt_cnt,
    output logic                 o_busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]          state_q, state_d;
    logic                grant_q, grant_d;
    logic                m_valid_q;
    logic [63:0]         m_data_q;
    logic [7:0]          m_keep_q;
    logic                m_last_q;
    logic [P_USER_W-1:0] m_user_q;
    logic [P_CNT_W-1:0]  cnt0_q, cnt1_q;

    logic w_stage_free;
    logic w_rdy0, w_rdy1;
    logic w_accept;
    logic w_sel_last;
    logic w_pkt_done;
    logic w_pick;

    // The output slice can take a beat when empty or being drained this edge
    assign w_stage_free = ~m_valid_q | m_axis_upper.ready;
    assign w_rdy0       = (state_q == ST_BUSY) & ~grant_q & w_stage_free;
    assign w_rdy1       = (state_q == ST_BUSY) &  grant_q & w_stage_free;
    assign w_accept     = (w_rdy0 & s_axis_p0.valid) | (w_rdy1 & s_axis_p1.valid);
    assign w_sel_last   = grant_q ? s_axis_p1.last : s_axis_p0.last;
    assign w_pkt_done   = w_accept & w_sel_last;

`ifdef ARB_STRICT_PRIO_EN
    // ICMP has absolute priority whenever it is requesting
    assign w_pick = s_axis_p1.valid;
`else
    logic rr_q;

    // Round-robin pointer: after a packet, favour the other port
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rr_q <= 1'b0;
        end else if (w_pkt_done) begin
            rr_q <= ~grant_q;
        end
    end

    assign w_pick = (s_axis_p0.valid & s_axis_p1.valid) ? rr_q : s_axis_p1.valid;
`endif

    // Next-state and grant selection; grant only changes in ST_IDLE
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (s_axis_p0.valid | s_axis_p1.valid) begin
                    grant_d = w_pick;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_pkt_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and grant registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Output register slice: load on accept, otherwise drain on ready
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_user_q  <= '0;
        end else if (w_accept) begin
            m_valid_q <= 1'b1;
            m_data_q  <= grant_q ? s_axis_p1.data : s_axis_p0.data;
            m_keep_q  <= grant_q ? s_axis_p1.keep : s_axis_p0.keep;
            m_last_q  <= w_sel_last;
            m_user_q  <= grant_q ? s_axis_p1.user : s_axis_p0.user;
        end else if (m_axis_upper.ready) begin
            m_valid_q <= 1'b0;
        end
    end

    // Completed-packet counters, wrapping modulo 2^P_CNT_W
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (w_pkt_done) begin
            if (grant_q) begin
                cnt1_q <= cnt1_q + P_CNT_W'(1);
            end else begin
                cnt0_q <= cnt0_q + P_CNT_W'(1);
            end
        end
    end

    assign s_axis_p0.ready    = w_rdy0;
    assign s_axis_p1.ready    = w_rdy1;
    assign m_axis_upper.valid = m_valid_q;
    assign m_axis_upper.data  = m_data_q;
    assign m_axis_upper.keep  = m_keep_q;
    assign m_axis_upper.last  = m_last_q;
    assign m_axis_upper.user  = m_user_q;
    assign o_p0_pkt_cnt       = cnt0_q;
    assign o_p1_pkt_cnt       = cnt1_q;
    assign o_busy             = (state_q == ST_BUSY);

endmodule

`default_nettype wire

// File: tb/tb_ip_tx_arbiter.sv
//==============================================================================
// Module   : tb_ip_tx_arbiter
// Brief    : Directed self-checking bench for ip_tx_arbiter. A second,
//            4-bit-counter instance exercises counter wrap.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ip_tx_arbiter;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [55:0] user;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] cnt0, cnt1;
    logic        busy;
    logic [3:0]  wcnt0, wcnt1;
    logic        wbusy;

    ip_tx_arbiter_if #(.P_USER_W(56)) p0 ();
    ip_tx_arbiter_if #(.P_USER_W(56)) p1 ();
    ip_tx_arbiter_if #(.P_USER_W(56)) mu ();
    ip_tx_arbiter_if #(.P_USER_W(56)) wp0 ();
    ip_tx_arbiter_if #(.P_USER_W(56)) wp1 ();
    ip_tx_arbiter_if #(.P_USER_W(56)) wm ();

    ip_tx_arbiter #(.P_USER_W(56), .P_CNT_W(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .s_axis_p0    (p0),
        .s_axis_p1    (p1),
        .m_axis_upper (mu),
        .o_p0_pkt_cnt (cnt0),
        .o_p1_pkt_cnt (cnt1),
        .o_busy       (busy)
    );

    ip_tx_arbiter #(.P_USER_W(56), .P_CNT_W(4)) dut_w (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .s_axis_p0    (wp0),
        .s_axis_p1    (wp1),
        .m_axis_upper (wm),
        .o_p0_pkt_cnt (wcnt0),
        .o_p1_pkt_cnt (wcnt1),
        .o_busy       (wbusy)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t q0[$];
    beat_t q1[$];
    beat_t outq[$];
    int    cyc_n;
    int    first_out;
    logic  mrdy_toggle;
    logic  rdy0_seen;
    logic  held_v;
    beat_t held;
    beat_t e2[4];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input int port, input int k, input int b, input int n);
        beat_t r;
        r.data = 64'hA5A5_0000_0000_0000 | (64'(port) << 16) | (64'(k) << 8) | 64'(b);
        r.keep = (b == n - 1) ? 8'h3F : 8'hFF;
        r.last = (b == n - 1);
        r.user = 56'h00_1000_0000_0000 | (56'(k) << 8) | 56'(port);
        return r;
    endfunction

    task automatic present();
        beat_t b;
        b = (q0.size() != 0) ? q0[0] : '0;
        p0.valid = (q0.size() != 0);
        p0.data = b.data; p0.keep = b.keep; p0.last = b.last; p0.user = b.user;
        b = (q1.size() != 0) ? q1[0] : '0;
        p1.valid = (q1.size() != 0);
        p1.data = b.data; p1.keep = b.keep; p1.last = b.last; p1.user = b.user;
    endtask

    // One clock: present beats, sample at negedge, advance sources after posedge
    task automatic cyc();
        beat_t ob;
        logic  a0, a1;
        present();
        @(negedge clk); #1;
        a0 = p0.valid & p0.ready;
        a1 = p1.valid & p1.ready;
        rdy0_seen = rdy0_seen | p0.ready;
        ob = {mu.data, mu.keep, mu.last, mu.user};
        if (held_v) begin
            chk("stall_valid", 256'(mu.valid), 256'(1));
            chk("stall_hold", 256'(ob), 256'(held));
        end
        held_v = mu.valid & ~mu.ready;
        held   = ob;
        if (mu.valid & mu.ready) begin
            if (first_out < 0) first_out = cyc_n;
            outq.push_back(ob);
        end
        @(posedge clk); #1;
        if (a0) ob = q0.pop_front();
        if (a1) ob = q1.pop_front();
        if (mrdy_toggle) mu.ready = ~mu.ready;
        cyc_n++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        held_v = 1'b0;
        q0.delete();
        q1.delete();
        present();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        mrdy_toggle = 1'b0;
        held_v = 1'b0;
        rdy0_seen = 1'b0;
        mu.ready = 1'b0;
        present();
        wp0.valid = 1'b0; wp0.data = '0; wp0.keep = '0; wp0.last = 1'b0; wp0.user = '0;
        wp1.valid = 1'b0; wp1.data = '0; wp1.keep = '0; wp1.last = 1'b0; wp1.user = '0;
        wm.ready = 1'b1;

        // ---- Reset state, then 20 idle cycles after release
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("in_reset", {mu.valid, mu.data, mu.keep, mu.user, mu.last, p0.ready, p1.ready, cnt0, cnt1, busy}, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            chk("idle_after_reset", {mu.valid, mu.data, mu.keep, mu.user, mu.last, p0.ready, p1.ready, cnt0, cnt1, busy}, '0);
        end

        // ---- p0 4-beat packet, m_ready=1
        @(posedge clk); #1;
        mu.ready = 1'b1;
        e2[0] = {64'h11, 8'hFF, 1'b0, 56'h00200011000001};
        e2[1] = {64'h22, 8'hFF, 1'b0, 56'h00200011000001};
        e2[2] = {64'h33, 8'hFF, 1'b0, 56'h00200011000001};
        e2[3] = {64'h44, 8'h0F, 1'b1, 56'h00200011000001};
        for (int i = 0; i < 4; i++) q0.push_back(e2[i]);
        cyc_n = 0; first_out = -1; outq.delete();
        repeat (10) cyc();
        chk("p0_latency", 256'(first_out), 256'(2));
        chk("p0_beats", 256'(outq.size()), 256'(4));
        for (int i = 0; i < 4 && i < outq.size(); i++) chk("p0_beat", 256'(outq[i]), 256'(e2[i]));
        chk("p0_cnt", 256'(cnt0), 256'(1));
        chk("p0_busy_end", 256'(busy), 256'(0));

        // ---- Both ports stream 2-beat packets
        do_reset();
        mu.ready = 1'b1;
`ifdef ARB_STRICT_PRIO_EN
        for (int k = 0; k < 10; k++) for (int b = 0; b < 2; b++) q1.push_back(mk(1, k, b, 2));
`else
        for (int k = 0; k < 5; k++) for (int b = 0; b < 2; b++) q1.push_back(mk(1, k, b, 2));
`endif
        for (int k = 0; k < 5; k++) for (int b = 0; b < 2; b++) q0.push_back(mk(0, k, b, 2));
        cyc_n = 0; first_out = -1; outq.delete();
        repeat (31) cyc();
        chk("rr_beats", 256'(outq.size()), 256'(20));
        for (int i = 0; i < 10; i++) begin
            for (int b = 0; b < 2; b++) begin
                if (2 * i + b < outq.size()) begin
`ifdef ARB_STRICT_PRIO_EN
                    chk("prio_order", 256'(outq[2*i+b]), 256'(mk(1, i, b, 2)));
`else
                    chk("rr_order", 256'(outq[2*i+b]), 256'(mk(i % 2, i / 2, b, 2)));
`endif
                end
            end
        end
`ifdef ARB_STRICT_PRIO_EN
        chk("prio_p0_cnt", 256'(cnt0), 256'(0));
        chk("prio_p1_cnt", 256'(cnt1), 256'(10));
`else
        chk("rr_p0_cnt", 256'(cnt0), 256'(5));
        chk("rr_p1_cnt", 256'(cnt1), 256'(5));
`endif

        // ---- 6-beat p1 packet with m_ready toggling each cycle
        do_reset();
        mu.ready = 1'b1;
        mrdy_toggle = 1'b1;
        rdy0_seen = 1'b0;
        for (int b = 0; b < 6; b++) q1.push_back(mk(1, 7, b, 6));
        cyc_n = 0; first_out = -1; outq.delete();
        repeat (30) cyc();
        mrdy_toggle = 1'b0;
        mu.ready = 1'b1;
        chk("tog_beats", 256'(outq.size()), 256'(6));
        for (int b = 0; b < 6 && b < outq.size(); b++) chk("tog_beat", 256'(outq[b]), 256'(mk(1, 7, b, 6)));
        chk("tog_p0_ready", 256'(rdy0_seen), 256'(0));
        chk("tog_p1_cnt", 256'(cnt1), 256'(1));
        chk("tog_p0_cnt", 256'(cnt0), 256'(0));

        // ---- Asynchronous reset on beat 3 of a 5-beat p1 packet
        do_reset();
        mu.ready = 1'b1;
        for (int b = 0; b < 5; b++) q1.push_back(mk(1, 9, b, 5));
        outq.delete();
        repeat (3) cyc();
        present();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outputs", {mu.valid, p0.ready, p1.ready, busy, mu.data}, '0);
        q1.delete();
        present();
        held_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int b = 0; b < 3; b++) q1.push_back(mk(1, 10, b, 3));
        outq.delete();
        repeat (10) cyc();
        chk("arst_new_beats", 256'(outq.size()), 256'(3));
        for (int b = 0; b < 3 && b < outq.size(); b++) chk("arst_new_beat", 256'(outq[b]), 256'(mk(1, 10, b, 3)));
        chk("arst_p1_cnt", 256'(cnt1), 256'(1));

        // ---- Counter wrap on the 4-bit instance: single-beat p0 packets
        @(posedge clk); #1;
        wp0.valid = 1'b1; wp0.last = 1'b1; wp0.keep = 8'h01; wp0.data = 64'h5A;
        repeat (30) @(posedge clk);
        @(negedge clk); #1;
        chk("wrap_allones", 256'(wcnt0), 256'(4'hF));
        @(posedge clk);
        @(posedge clk); #1;
        chk("wrap_zero", 256'(wcnt0), 256'(0));
        chk("wrap_p1_cnt", 256'(wcnt1), 256'(0));
        wp0.valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
